// File: rtl/systolic_pkg.sv
// Shared types and index-width helpers for the systolic array frame blocks.
package systolic_pkg;

  // Result collector operating modes: gather rows, then stream elements.
  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } collector_state_t;

  // Default array dimension used by the frame; blocks may override locally.
  localparam int SYS_MATRIX_SIZE = 2;

  // Row/column index width shared by the scheduler, skewer and collector.
  localparam int IDX_W = $clog2(SYS_MATRIX_SIZE);

  // Index width for an arbitrary dimension, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_collector.sv
// Gathers MATRIX_SIZE result rows from the systolic frame into a local
// buffer, then streams the matrix row-major one element per handshake.
module result_collector
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [DATA_SIZE-1:0]   in_row [MATRIX_SIZE],
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_SIZE-1:0]   out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] frame_count
);

  localparam int W = idx_width(MATRIX_SIZE);
  localparam logic [W-1:0] LAST_IDX = W'(MATRIX_SIZE - 1);

  collector_state_t       state_reg, state_next;
  logic [W-1:0]           row_idx_reg, row_idx_next;
  logic [W-1:0]           col_idx_reg, col_idx_next;
  logic [W-1:0]           elem_row_reg, elem_row_next;
  logic [COUNT_WIDTH-1:0] frame_count_reg, frame_count_next;

  logic [DATA_SIZE-1:0]   buf_mem [MATRIX_SIZE][MATRIX_SIZE];
  logic [MATRIX_SIZE-1:0] row_wr_en;

  logic in_fire;
  logic out_fire;

  // One write enable per buffer row, selected by the current row index.
  for (genvar gi = 0; gi < MATRIX_SIZE; gi++) begin : g_row_wr_en
    assign row_wr_en[gi] = in_fire && (row_idx_reg == W'(gi));
  end

  // Buffer capture; slots are only written in COLLECT, so DRAIN reads are stable.
  always_ff @(posedge clk) begin
    for (int r = 0; r < MATRIX_SIZE; r++) begin
      if (row_wr_en[r]) begin
        for (int c = 0; c < MATRIX_SIZE; c++) begin
          buf_mem[r][c] <= in_row[c];
        end
      end
    end
  end

  // State, index and frame counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= COLLECT;
      row_idx_reg     <= '0;
      col_idx_reg     <= '0;
      elem_row_reg    <= '0;
      frame_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      row_idx_reg     <= row_idx_next;
      col_idx_reg     <= col_idx_next;
      elem_row_reg    <= elem_row_next;
      frame_count_reg <= frame_count_next;
    end
  end

  // Next-state and output decode; outputs depend only on registered values.
  always_comb begin
    state_next       = state_reg;
    row_idx_next     = row_idx_reg;
    col_idx_next     = col_idx_reg;
    elem_row_next    = elem_row_reg;
    frame_count_next = frame_count_reg;

    in_ready  = (state_reg == COLLECT);
    out_valid = (state_reg == DRAIN);
    busy      = (state_reg == DRAIN);
    out_last  = (state_reg == DRAIN) && (elem_row_reg == LAST_IDX) &&
                (col_idx_reg == LAST_IDX);
    out_data  = out_valid ? buf_mem[elem_row_reg][col_idx_reg] : '0;

    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;

    case (state_reg)
      COLLECT: begin
        if (in_fire) begin
          if (row_idx_reg == LAST_IDX) begin
            row_idx_next  = '0;
            col_idx_next  = '0;
            elem_row_next = '0;
            state_next    = DRAIN;
          end else begin
            row_idx_next = row_idx_reg + W'(1);
          end
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (col_idx_reg == LAST_IDX) begin
            col_idx_next = '0;
            if (elem_row_reg == LAST_IDX) begin
              elem_row_next    = '0;
              frame_count_next = frame_count_reg + COUNT_WIDTH'(1);
              state_next       = COLLECT;
            end else begin
              elem_row_next = elem_row_reg + W'(1);
            end
          end else begin
            col_idx_next = col_idx_reg + W'(1);
          end
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector with MATRIX_SIZE=2, DATA_SIZE=32 and a
// 2-bit frame counter so that wrap-around is reachable quickly.
module tb_result_collector;

  localparam int MS = 2;
  localparam int DS = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [DS-1:0] in_row [MS];
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DS-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic [CW-1:0] frame_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_fc    = 0;

  always #5 clk = ~clk;

  result_collector #(
    .MATRIX_SIZE(MS),
    .DATA_SIZE  (DS),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_row     (in_row),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .frame_count(frame_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " in_ready"},  32'(in_ready),  32'd1);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " out_data"},  out_data,       32'd0);
    check({tag, " out_last"},  32'(out_last),  32'd0);
    check({tag, " busy"},      32'(busy),      32'd0);
  endtask

  // Offer a row and hold it until the handshake edge; leaves in_valid low.
  task automatic send_row(input logic [31:0] a, input logic [31:0] b);
    int wait_cyc = 0;
    in_row[0] = a;
    in_row[1] = b;
    in_valid  = 1'b1;
    while (!in_ready && wait_cyc < 50) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    if (!in_ready) check("send_row timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    $display("row accepted {%0d,%0d}", a, b);
    in_valid = 1'b0;
  endtask

  // Drain one frame with a given out_ready pattern (then ready held high).
  task automatic drain_frame(input logic [31:0] e [4], input logic [15:0] pat, input int npat);
    int k = 0;
    int cyc = 0;
    while (k < 4 && cyc < 40) begin
      out_ready = (cyc < npat) ? pat[cyc] : 1'b1;
      check("drain out_valid", 32'(out_valid), 32'd1);
      check("drain in_ready",  32'(in_ready),  32'd0);
      check("drain busy",      32'(busy),      32'd1);
      check("drain out_data",  out_data,       e[k]);
      check("drain out_last",  32'(out_last),  32'(k == 3));
      @(posedge clk); #1;
      if (out_ready) begin
        $display("element %0d transferred: expected %0d", k, e[k]);
        k++;
      end
      cyc++;
    end
    out_ready = 1'b0;
    if (k < 4) check("drain timeout", 32'(k), 32'd4);
    exp_fc = (exp_fc + 1) % 4;
    check("frame_count", 32'(frame_count), 32'(exp_fc));
    check_idle("after drain");
  endtask

  initial begin
    in_row[0] = '0;
    in_row[1] = '0;

    // Reset held three cycles.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_idle("reset");
    check("reset frame_count", 32'(frame_count), 32'd0);

    // Basic frame, consecutive rows, sink always ready.
    send_row(32'd1, 32'd2);
    check("mid-collect out_valid", 32'(out_valid), 32'd0);
    send_row(32'd3, 32'd4);
    drain_frame('{32'd1, 32'd2, 32'd3, 32'd4}, 16'h0000, 0);

    // Backpressure pattern 0,1,0,0,1,1,1.
    send_row(32'd1, 32'd2);
    send_row(32'd3, 32'd4);
    drain_frame('{32'd1, 32'd2, 32'd3, 32'd4}, 16'b1110010, 7);

    // Input gap of three cycles between rows.
    send_row(32'd1, 32'd2);
    repeat (3) begin
      @(posedge clk); #1;
      check("gap in_ready",  32'(in_ready),  32'd1);
      check("gap out_valid", 32'(out_valid), 32'd0);
    end
    send_row(32'd3, 32'd4);
    drain_frame('{32'd1, 32'd2, 32'd3, 32'd4}, 16'h0000, 0);

    // Early offer: row {9,9} held valid throughout DRAIN.
    send_row(32'd1, 32'd2);
    send_row(32'd3, 32'd4);
    in_row[0] = 32'd9;
    in_row[1] = 32'd9;
    in_valid  = 1'b1;
    drain_frame('{32'd1, 32'd2, 32'd3, 32'd4}, 16'h0000, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("early row taken, still collecting", 32'(in_ready), 32'd1);
    send_row(32'd10, 32'd11);
    drain_frame('{32'd9, 32'd9, 32'd10, 32'd11}, 16'h0000, 0);

    // Reset during DRAIN after two elements have gone out.
    send_row(32'd21, 32'd22);
    send_row(32'd23, 32'd24);
    out_ready = 1'b1;
    check("pre-reset elem0", out_data, 32'd21);
    @(posedge clk); #1;
    check("pre-reset elem1", out_data, 32'd22);
    @(posedge clk); #1;
    out_ready = 1'b0;
    reset = 1'b1;
    #1;
    check_idle("async reset");
    check("async reset frame_count", 32'(frame_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_fc = 0;
    @(posedge clk); #1;
    check_idle("post reset");
    send_row(32'd5, 32'd6);
    send_row(32'd7, 32'd8);
    drain_frame('{32'd5, 32'd6, 32'd7, 32'd8}, 16'h0000, 0);

    // Counter wrap over five frames from a fresh reset: 1,2,3,0,1.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_fc = 0;
    check("wrap start frame_count", 32'(frame_count), 32'd0);
    for (int f = 0; f < 5; f++) begin
      send_row(32'(100 + 4 * f), 32'(101 + 4 * f));
      send_row(32'(102 + 4 * f), 32'(103 + 4 * f));
      drain_frame('{32'(100 + 4 * f), 32'(101 + 4 * f), 32'(102 + 4 * f), 32'(103 + 4 * f)},
                  16'h0000, 0);
    end
    check("wrap final frame_count", 32'(frame_count), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
